// File: rtl/derandomizer.sv
// -----------------------------------------------------------------------------
// derandomizer
//
// Receive-side physical-layer descrambler. Regenerates the Gold-code
// scrambling sequence Rn in {0,1,2,3} from two 18-bit LFSRs and de-rotates
// each received complex symbol by exp(-j*pi*Rn/2). The sequence restarts on
// every start-of-frame strobe. The block sits between the demodulator symbol
// stream and the frame deframer/decoder.
//
// Parameters
//   W          signed width of each I/Q sample
//   FRAME_LEN  symbols per scrambled frame (>= 2)
//   CNT_W      in-frame counter width, 2**CNT_W >= FRAME_LEN
//
// Ports
//   i_clk      clock
//   i_reset    synchronous, active-high reset (wins over any input)
//   i_valid    input symbol valid
//   i_sof      first symbol of a frame, qualified by i_valid
//   i_i, i_q   signed received symbol
//   o_valid    output symbol valid (1-cycle latency, registered)
//   o_sof      first symbol of a frame, aligned with o_valid
//   o_eof      last symbol of a frame, aligned with o_valid
//   o_i, o_q   signed de-rotated symbol (hold value while o_valid is low)
//   o_rn       Rn applied to the current output symbol (debug)
//   o_err      pulse: i_sof arrived while a frame was still in progress
//   o_drop     pulse: valid symbol without i_sof arrived while idle
//
// Build option
//   DERANDOMIZER_SAT_EN  when defined, negation saturates so that
//                        -(-2**(W-1)) becomes 2**(W-1)-1; otherwise the
//                        negation wraps in two's complement.
// -----------------------------------------------------------------------------
module derandomizer #(
    parameter int W         = 8,
    parameter int FRAME_LEN = 16200,
    parameter int CNT_W     = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic                i_sof,
    input  logic signed [W-1:0] i_i,
    input  logic signed [W-1:0] i_q,
    output logic                o_valid,
    output logic                o_sof,
    output logic                o_eof,
    output logic signed [W-1:0] o_i,
    output logic signed [W-1:0] o_q,
    output logic [1:0]          o_rn,
    output logic                o_err,
    output logic                o_drop
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [17:0]         X_SEED   = 18'h00001;
    localparam logic [17:0]         Y_SEED   = 18'h3FFFF;
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic signed [W-1:0] S_MIN    = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] S_MAX    = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_t;

    // -------------------------------------------------------------------------
    // Sequence generator helpers
    // -------------------------------------------------------------------------
    function automatic logic [17:0] f_x_adv(input logic [17:0] x);
        return {x[7] ^ x[0], x[17:1]};
    endfunction

    function automatic logic [17:0] f_y_adv(input logic [17:0] y);
        return {y[10] ^ y[7] ^ y[5] ^ y[0], y[17:1]};
    endfunction

    // The quadrature tap set of this Gold code skips y[7]; with it the seed
    // state yields Rn=0 for the first symbol of every frame.
    function automatic logic [1:0] f_rn(input logic [17:0] x, input logic [17:0] y);
        logic msb;
        logic lsb;
        msb = x[4] ^ x[6] ^ x[15]
            ^ y[5] ^ y[6] ^ y[8] ^ y[9] ^ y[10] ^ y[11]
            ^ y[12] ^ y[13] ^ y[14] ^ y[15];
        lsb = x[0] ^ y[0];
        return {msb, lsb};
    endfunction

    // Negation; only the most negative code needs special handling.
    function automatic logic signed [W-1:0] f_neg(input logic signed [W-1:0] a);
        logic signed [W-1:0] neg;
        neg = -a;
`ifdef DERANDOMIZER_SAT_EN
        if (a == S_MIN) begin
            neg = S_MAX;
        end
`else
        if (a == S_MIN) begin
            neg = S_MIN;
        end
`endif
        return neg;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [17:0]      r_x;
    logic [17:0]      r_y;

    // -------------------------------------------------------------------------
    // Datapath: an sof symbol is processed with the seed state in the same
    // cycle the seeds are reloaded, so the generator source is muxed here.
    // -------------------------------------------------------------------------
    logic [17:0]         w_x_src;
    logic [17:0]         w_y_src;
    logic [1:0]          w_rn;
    logic signed [W-1:0] w_i_rot;
    logic signed [W-1:0] w_q_rot;
    logic                w_accept;
    logic                w_last;

    always_comb begin
        w_x_src  = i_sof ? X_SEED : r_x;
        w_y_src  = i_sof ? Y_SEED : r_y;
        w_rn     = f_rn(w_x_src, w_y_src);
        w_accept = i_valid & (i_sof | (r_state == StRun));
        w_last   = (r_cnt == LAST_CNT);

        w_i_rot = i_i;
        w_q_rot = i_q;
        unique case (w_rn)
            2'd0: begin
                w_i_rot = i_i;
                w_q_rot = i_q;
            end
            2'd1: begin
                w_i_rot = i_q;
                w_q_rot = f_neg(i_i);
            end
            2'd2: begin
                w_i_rot = f_neg(i_i);
                w_q_rot = f_neg(i_q);
            end
            2'd3: begin
                w_i_rot = f_neg(i_q);
                w_q_rot = i_i;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_x     <= X_SEED;
            r_y     <= Y_SEED;
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_eof   <= 1'b0;
            o_i     <= '0;
            o_q     <= '0;
            o_rn    <= 2'd0;
            o_err   <= 1'b0;
            o_drop  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_eof   <= 1'b0;
            o_err   <= 1'b0;
            o_drop  <= 1'b0;

            // Generator and sample path advance only on accepted symbols.
            if (w_accept) begin
                o_valid <= 1'b1;
                o_sof   <= i_sof;
                o_i     <= w_i_rot;
                o_q     <= w_q_rot;
                o_rn    <= w_rn;
                r_x     <= f_x_adv(w_x_src);
                r_y     <= f_y_adv(w_y_src);
            end

            if (i_valid) begin
                unique case (r_state)
                    StIdle: begin
                        if (i_sof) begin
                            r_state <= StRun;
                            r_cnt   <= CNT_W'(1);
                        end else begin
                            o_drop <= 1'b1;
                        end
                    end
                    StRun: begin
                        if (i_sof) begin
                            // Resync: abort the current frame without an eof,
                            // even when this was its last slot.
                            o_err <= 1'b1;
                            r_cnt <= CNT_W'(1);
                        end else if (w_last) begin
                            o_eof   <= 1'b1;
                            r_state <= StIdle;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/derandomizer.md
# derandomizer

Receive-side counterpart of the CCSDS 131.2 Appendix C physical-layer scrambler. It regenerates the same Gold-code scrambling sequence Rn ∈ {0,1,2,3} and de-rotates each received complex symbol by exp(-jπ·Rn/2). The sequence is frame-aligned via a start-of-frame strobe. The block sits between the demodulator's symbol stream and the frame deframer/decoder.

## Interface
- `W`, 8 — signed width of each I/Q sample.
- `FRAME_LEN`, 16200 — symbols per scrambled frame (≥2).
- `CNT_W`, 16 — width of the in-frame symbol counter; must satisfy 2^CNT_W ≥ FRAME_LEN.

- `i_clk`  in  1  clock.
- `i_reset`  in  1  reset; synchronous, active-high. Clock is `i_clk`.
- `i_valid`  in  1  input symbol valid.
- `i_sof`  in  1  first symbol of a frame; qualified by `i_valid`.
- `i_i`, `i_q`  in  W  signed received symbol.
- `o_valid`  out  1  output symbol valid.
- `o_sof`, `o_eof`  out  1  first / last symbol of a frame, aligned with `o_valid`.
- `o_i`, `o_q`  out  W  signed de-rotated symbol.
- `o_rn`  out  2  Rn applied to the current output symbol (debug).
- `o_err`  out  1  one-cycle pulse when `i_sof` arrives while a frame is still in progress.
- `o_drop`  out  1  one-cycle pulse when a valid symbol arrives in IDLE without `i_sof`.

## Operation
- **Generator:** two 18-bit LFSRs.
  - x seed = 18'h00001; y seed = 18'h3FFFF.
  - Advance: x ← {x[7]^x[0], x[17:1]}; y ← {y[10]^y[7]^y[5]^y[0], y[17:1]}.
  - Rn = 2·(x[4]^x[6]^x[15]^y[5]^y[6]^…^y[15]) + (x[0]^y[0]).
- **De-rotation** (conjugate of the transmit rotation):
  - Rn=0 → (I, Q)
  - Rn=1 → (Q, −I)
  - Rn=2 → (−I, −Q)
  - Rn=3 → (−Q, I)
- **FSM states:**
  - IDLE
    - `i_valid & i_sof`: reload seeds, process the symbol with the seed-state Rn, advance the LFSRs, set count=1, go to RUN.
    - `i_valid & !i_sof`: no output; pulse `o_drop`.
  - RUN
    - `i_valid & !i_sof`: process the symbol, advance the LFSRs, increment count.
    - Symbol with count == FRAME_LEN−1: emitted with `o_eof=1`; go to IDLE.
    - `i_valid & i_sof`: pulse `o_err`, treat the symbol as a new frame start (reload seeds, count=1), stay in RUN. No `o_eof` is emitted for the aborted frame.
- The LFSRs and counter never advance when `i_valid`=0.
- Seed reload and processing of the sof symbol occur in the same cycle.
- An sof symbol arriving at count == FRAME_LEN−1 is handled as resync: `o_err`=1, and that symbol is output with `o_sof`=1, `o_eof`=0.
- FRAME_LEN is independent of the LFSR period; the count wraps only via the FSM.

## Timing
- Latency: exactly 1 cycle from input to `o_*`. All outputs are registered.
- No back-pressure; one symbol per cycle is accepted sustainably.
- `o_sof`, `o_eof`, `o_err`, `o_drop` are single-cycle pulses.
- Reset (wins over any concurrent input) sets:
  - state IDLE, count 0;
  - LFSRs to their seeds;
  - all outputs 0 (`o_i`=`o_q`=0, `o_rn`=0).
- Reset mid-frame discards the frame. The first symbol accepted after reset is accepted only if it carries `i_sof`.

## Configuration
- Macro: `DERANDOMIZER_SAT_EN`.
- **Defined:** negation saturates, so −(−2^(W−1)) = 2^(W−1)−1 (W=8: −(−128) → 127).
- **Undefined:** two's-complement wrap, so −(−128) → −128.
- The arithmetic paths are otherwise identical.

## Test plan
- **Constant input:** reset, then a frame with I=10, Q=20 constant.
  - Outputs 0..2 = (10,20), (20,−10), (20,−10).
  - `o_rn` = 0,1,1; `o_sof` on the first output.
- **Full frame:** FRAME_LEN=8, 8 valid symbols → `o_eof` on the 8th output, then state IDLE.
  - A 9th symbol without sof → no `o_valid`, `o_drop`=1.
- **Resync:** `i_sof` at symbol 4 of a frame → `o_err` pulse; that output carries `o_sof`=1, `o_rn`=0, and the sequence restarts at 0,1,1.
- **Gapped input:** idle cycles inserted between valid symbols → `o_rn` sequence identical to the gap-free run; no output during gaps.
- **Saturation:** Rn=2 with I=−128, Q=5.
  - With `DERANDOMIZER_SAT_EN` → (127, −5).
  - Without → (−128, −5).
- **Mid-frame reset:** assert `i_reset` mid-frame → all outputs 0 next cycle.
  - A following sof frame reproduces the reference Rn sequence from 0 against a bit-exact golden model over 1000 symbols.
